// File: rtl/sgmii_pkg.sv
// Shared definitions for the SGMII receive rate-adaptation path.
// Holds the speed encodings, the default replication factors and a helper
// that returns the replication factor and the mid-group sample phase for
// a given speed setting.
package sgmii_pkg;

  localparam logic [1:0] SPD_10   = 2'b00;
  localparam logic [1:0] SPD_100  = 2'b01;
  localparam logic [1:0] SPD_1000 = 2'b10;

  localparam int REP_10_DEFAULT  = 100;
  localparam int REP_100_DEFAULT = 10;

  typedef struct packed {
    int unsigned rep;
    int unsigned samp;
  } rep_cfg_t;

  // Speed code 2'b11 is reserved and behaves as gigabit.
  function automatic logic [1:0] norm_speed(input logic [1:0] spd);
    return (spd == 2'b11) ? SPD_1000 : spd;
  endfunction

  // Replication factor and sample phase (middle of the group) per speed.
  function automatic rep_cfg_t get_rep_cfg(input logic [1:0] spd,
                                           input int unsigned rep_10,
                                           input int unsigned rep_100);
    rep_cfg_t cfg;
    case (spd)
      SPD_10:  cfg.rep = rep_10;
      SPD_100: cfg.rep = rep_100;
      default: cfg.rep = 1;
    endcase
    cfg.samp = cfg.rep / 2;
    return cfg;
  endfunction

endpackage

// File: rtl/sgmii_rx_phase_ctr.sv
// Replication-group phase tracker for the SGMII receive rate adapter.
// Keeps a free-running phase counter that wraps every REP cycles, and
// realigns it to zero on a rising rx_dv_in or when the speed setting moves.
// Ports:
//   clk, reset_n  - clock and asynchronous active-low reset
//   speed         - requested line speed (2'b11 handled as gigabit)
//   rx_dv_in      - receive data valid from the PCS
//   dv_rise/fall  - rx_dv_in edge indications for the current cycle
//   spd_chg       - speed differs from the one registered last cycle
//   gig           - current speed is gigabit (no replication)
//   phase_zero    - current cycle is the first of a group
//   samp_ph       - current cycle is the group's sample phase
//   grp_end       - current cycle is the last of a group
module sgmii_rx_phase_ctr
  import sgmii_pkg::*;
#(
  parameter int REP_100 = REP_100_DEFAULT,
  parameter int REP_10  = REP_10_DEFAULT,
  parameter int CNT_W   = 7
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] speed,
  input  logic       rx_dv_in,
  output logic       dv_rise,
  output logic       dv_fall,
  output logic       spd_chg,
  output logic       gig,
  output logic       phase_zero,
  output logic       samp_ph,
  output logic       grp_end
);

  logic [1:0]       spd_n;
  logic [1:0]       spd_q;
  logic             dv_q;
  logic [CNT_W-1:0] phase_q;
  logic [CNT_W-1:0] phase_d;
  logic [CNT_W-1:0] last_ph;
  rep_cfg_t         cfg;

  // The phase of the current cycle is derived from last cycle's phase so
  // that a realignment (dv rise or speed change) takes effect immediately.
  // The >= guards against a phase left over from a longer group.
  always_comb begin
    spd_n   = norm_speed(speed);
    cfg     = get_rep_cfg(spd_n, REP_10, REP_100);
    last_ph = CNT_W'(cfg.rep - 1);
    dv_rise = rx_dv_in & ~dv_q;
    dv_fall = ~rx_dv_in & dv_q;
    spd_chg = (spd_n != spd_q);
    gig     = (spd_n == SPD_1000);
    if (dv_rise || spd_chg || (phase_q >= last_ph)) begin
      phase_d = '0;
    end else begin
      phase_d = phase_q + CNT_W'(1);
    end
    phase_zero = (phase_d == '0);
    samp_ph    = (phase_d == CNT_W'(cfg.samp));
    grp_end    = (phase_d == last_ph);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      spd_q   <= SPD_1000;
      dv_q    <= 1'b0;
      phase_q <= '0;
    end else begin
      spd_q   <= spd_n;
      dv_q    <= rx_dv_in;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/sgmii_rx_rate_adapt.sv
// SGMII receive rate adaptation. At 10/100 Mb/s every GMII byte arrives
// replicated REP times on the 125 MHz clock; this block decimates each
// replication group to one byte, merges error/valid status over the
// group, flags groups whose bytes disagree or whose dv drops mid-group,
// and pulses rx_stb once per group. At gigabit it is a one-register
// pass-through with rx_stb high every cycle.
// Ports:
//   clk, reset_n           - clock and asynchronous active-low reset
//   speed                  - 00=10M, 01=100M, 10/11=1000M
//   rxd_in/rx_dv_in/rx_er_in - replicated GMII receive bus from the PCS
//   err_cnt_clr            - synchronous clear of err_cnt (wins over count)
//   rxd_out/rx_dv_out/rx_er_out - decimated bus, new when rx_stb=1
//   rx_stb                 - one-cycle strobe per completed group
//   err_cnt                - saturating count of inconsistent/truncated groups
module sgmii_rx_rate_adapt
  import sgmii_pkg::*;
#(
  parameter int REP_100  = REP_100_DEFAULT,
  parameter int REP_10   = REP_10_DEFAULT,
  parameter int CNT_W    = 7,
  parameter int ERRCNT_W = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [1:0]          speed,
  input  logic [7:0]          rxd_in,
  input  logic                rx_dv_in,
  input  logic                rx_er_in,
  input  logic                err_cnt_clr,
  output logic [7:0]          rxd_out,
  output logic                rx_dv_out,
  output logic                rx_er_out,
  output logic                rx_stb,
  output logic [ERRCNT_W-1:0] err_cnt
);

  logic       dv_rise, dv_fall, spd_chg, gig;
  logic       phase_zero, samp_ph, grp_end;

  logic [7:0] ref_q, samp_q;
  logic       ref_dv_q, er_acc, mis_acc, trunc_acc, drop_q;

  logic [7:0] ref_eff, samp_eff;
  logic       dv_eff, er_eff, mis_eff, trunc_eff, drop_eff;
  logic       dv_out_n, er_out_n, err_hit;

  sgmii_rx_phase_ctr #(
    .REP_100 (REP_100),
    .REP_10  (REP_10),
    .CNT_W   (CNT_W)
  ) u_phase (
    .clk        (clk),
    .reset_n    (reset_n),
    .speed      (speed),
    .rx_dv_in   (rx_dv_in),
    .dv_rise    (dv_rise),
    .dv_fall    (dv_fall),
    .spd_chg    (spd_chg),
    .gig        (gig),
    .phase_zero (phase_zero),
    .samp_ph    (samp_ph),
    .grp_end    (grp_end)
  );

  // Group status including the current cycle. A phase-0 cycle restarts
  // every accumulator from the incoming bus, which also covers the clear
  // on a speed change (that cycle is always phase 0). The byte compare is
  // skipped at gigabit, where there is nothing to compare against.
  always_comb begin
    ref_eff   = ref_q;
    dv_eff    = ref_dv_q;
    samp_eff  = samp_q;
    er_eff    = er_acc | rx_er_in;
    mis_eff   = mis_acc;
    trunc_eff = trunc_acc | dv_fall;
    if (phase_zero) begin
      ref_eff   = rxd_in;
      dv_eff    = rx_dv_in;
      er_eff    = rx_er_in;
      mis_eff   = 1'b0;
      trunc_eff = 1'b0;
    end
    if (samp_ph) begin
      samp_eff = rxd_in;
    end
    if (rx_dv_in && !gig && (rxd_in != ref_eff)) begin
      mis_eff = 1'b1;
    end

    // A speed change arms the drop; only a later dv rise releases it, so a
    // rise on the change cycle itself is still dropped.
    drop_eff = drop_q;
    if (spd_chg) begin
      drop_eff = 1'b1;
    end else if (dv_rise) begin
      drop_eff = 1'b0;
    end

    // Error is reported inside a frame, or outside one when the PCS flagged
    // it itself (carrier extend / false carrier).
    dv_out_n = dv_eff & ~drop_eff;
    er_out_n = (er_eff | mis_eff | trunc_eff) & (dv_out_n | er_eff);
    err_hit  = grp_end & (mis_eff | trunc_eff);
  end

  // Group accumulators and drop flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ref_q     <= '0;
      ref_dv_q  <= 1'b0;
      samp_q    <= '0;
      er_acc    <= 1'b0;
      mis_acc   <= 1'b0;
      trunc_acc <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      ref_q     <= ref_eff;
      ref_dv_q  <= dv_eff;
      samp_q    <= samp_eff;
      er_acc    <= er_eff;
      mis_acc   <= mis_eff;
      trunc_acc <= trunc_eff;
      drop_q    <= drop_eff;
    end
  end

  // Output register: loaded on the last cycle of a group, so the decimated
  // byte appears together with rx_stb on the following cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rxd_out   <= '0;
      rx_dv_out <= 1'b0;
      rx_er_out <= 1'b0;
      rx_stb    <= 1'b0;
    end else begin
      rx_stb <= grp_end;
      if (grp_end) begin
        rxd_out   <= samp_eff;
        rx_dv_out <= dv_out_n;
        rx_er_out <= er_out_n;
      end
    end
  end

  // Saturating error counter; the clear takes priority over a count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_cnt <= '0;
    end else if (err_cnt_clr) begin
      err_cnt <= '0;
    end else if (err_hit && (err_cnt != '1)) begin
      err_cnt <= err_cnt + ERRCNT_W'(1);
    end
  end

endmodule

// File: tb/tb_sgmii_rx_rate_adapt.sv
// Bench for sgmii_rx_rate_adapt. Each issued replication group pushes its
// expected decimated output and the clock edge on which it is registered;
// a monitor on the falling edge pops and compares when that edge arrives.
// A second instance with a 4-bit error counter reaches all-ones quickly.
module tb_sgmii_rx_rate_adapt;

  typedef struct {
    int          cyc;
    logic [7:0]  rxd;
    logic        dv;
    logic        er;
    logic [15:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  speed;
  logic [7:0]  rxd_in;
  logic        rx_dv_in;
  logic        rx_er_in;
  logic        err_cnt_clr;
  logic [7:0]  rxd_out;
  logic        rx_dv_out, rx_er_out, rx_stb;
  logic [15:0] err_cnt;
  logic [7:0]  rxd_s;
  logic        rx_dv_s, rx_er_s, rx_stb_s;
  logic [3:0]  err_cnt_s;

  int   edge_cnt = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  always #4 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  sgmii_rx_rate_adapt dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .speed       (speed),
    .rxd_in      (rxd_in),
    .rx_dv_in    (rx_dv_in),
    .rx_er_in    (rx_er_in),
    .err_cnt_clr (err_cnt_clr),
    .rxd_out     (rxd_out),
    .rx_dv_out   (rx_dv_out),
    .rx_er_out   (rx_er_out),
    .rx_stb      (rx_stb),
    .err_cnt     (err_cnt)
  );

  sgmii_rx_rate_adapt #(.ERRCNT_W(4)) dut_sat (
    .clk         (clk),
    .reset_n     (reset_n),
    .speed       (speed),
    .rxd_in      (rxd_in),
    .rx_dv_in    (rx_dv_in),
    .rx_er_in    (rx_er_in),
    .err_cnt_clr (err_cnt_clr),
    .rxd_out     (rxd_s),
    .rx_dv_out   (rx_dv_s),
    .rx_er_out   (rx_er_s),
    .rx_stb      (rx_stb_s),
    .err_cnt     (err_cnt_s)
  );

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)",
               name, act, req, edge_cnt);
    end
  endtask

  // Plain bus cycles with no expectation attached (idle, partial groups).
  task automatic drive(input int n, input logic [7:0] d, input logic dv);
    for (int i = 0; i < n; i++) begin
      rxd_in   = d;
      rx_dv_in = dv;
      rx_er_in = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  // One replication group of byte d (dv=1 from phase 0). bad_ph corrupts
  // one phase with d^F0, fall_ph drops dv from that phase on, clr_ph pulses
  // err_cnt_clr on that phase; -1 disables each. The expected output is
  // registered on the group's last edge.
  task automatic apply_stimulus(input logic [7:0] d, input int rep,
                                input int bad_ph, input int fall_ph,
                                input int clr_ph, input logic e_dv,
                                input logic e_er, input logic [15:0] e_cnt);
    exp_t e;
    e.cyc = edge_cnt + rep;
    e.rxd = d;
    e.dv  = e_dv;
    e.er  = e_er;
    e.cnt = e_cnt;
    sb.push_back(e);
    for (int p = 0; p < rep; p++) begin
      rxd_in      = (p == bad_ph) ? (d ^ 8'hF0) : d;
      rx_dv_in    = (fall_ph < 0) || (p < fall_ph);
      rx_er_in    = 1'b0;
      err_cnt_clr = (p == clr_ph);
      @(posedge clk);
      #1;
    end
    err_cnt_clr = 1'b0;
  endtask

  // Scoreboard monitor: compares the head entry on the edge it is due.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0 && sb[0].cyc == edge_cnt) begin
      e = sb.pop_front();
      check_output("rx_stb", 32'(rx_stb), 32'd1);
      check_output("rxd_out", 32'(rxd_out), 32'(e.rxd));
      check_output("rx_dv_out", 32'(rx_dv_out), 32'(e.dv));
      check_output("rx_er_out", 32'(rx_er_out), 32'(e.er));
      check_output("err_cnt", 32'(err_cnt), 32'(e.cnt));
    end
  end

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset_n     = 1'b0;
    speed       = 2'b10;
    rxd_in      = '0;
    rx_dv_in    = 1'b0;
    rx_er_in    = 1'b0;
    err_cnt_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("reset_rx_stb", 32'(rx_stb), 32'd0);
    check_output("reset_rxd_out", 32'(rxd_out), 32'd0);
    check_output("reset_rx_dv_out", 32'(rx_dv_out), 32'd0);
    check_output("reset_rx_er_out", 32'(rx_er_out), 32'd0);
    check_output("reset_err_cnt", 32'(err_cnt), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    drive(5, 8'h00, 1'b0);

    $display("[TB] gigabit pass-through frame");
    for (int i = 0; i < 64; i++) begin
      apply_stimulus(8'(i), 1, -1, -1, -1, 1'b1, 1'b0, 16'd0);
    end
    drive(4, 8'h00, 1'b0);

    $display("[TB] 100M preamble decimation");
    speed = 2'b01;
    drive(25, 8'h00, 1'b0);
    for (int i = 0; i < 7; i++) begin
      apply_stimulus(8'h55, 10, -1, -1, -1, 1'b1, 1'b0, 16'd0);
    end
    apply_stimulus(8'hD5, 10, -1, -1, -1, 1'b1, 1'b0, 16'd0);
    drive(13, 8'h00, 1'b0);

    $display("[TB] 100M truncated last group");
    apply_stimulus(8'h11, 10, -1, -1, -1, 1'b1, 1'b0, 16'd0);
    apply_stimulus(8'h22, 10, -1, -1, -1, 1'b1, 1'b0, 16'd0);
    apply_stimulus(8'h33, 10, -1, 4, -1, 1'b1, 1'b1, 16'd1);
    drive(7, 8'h00, 1'b0);

    $display("[TB] speed change mid-frame");
    apply_stimulus(8'h01, 10, -1, -1, -1, 1'b1, 1'b0, 16'd1);
    apply_stimulus(8'h02, 10, -1, -1, -1, 1'b1, 1'b0, 16'd1);
    drive(3, 8'h03, 1'b1);
    speed = 2'b00;
    apply_stimulus(8'h03, 100, -1, -1, -1, 1'b0, 1'b0, 16'd1);
    apply_stimulus(8'h03, 100, -1, -1, -1, 1'b0, 1'b0, 16'd1);
    drive(1, 8'h00, 1'b0);
    err_cnt_clr = 1'b1;
    drive(1, 8'h00, 1'b0);
    err_cnt_clr = 1'b0;
    check_output("err_cnt_after_clr", 32'(err_cnt), 32'd0);

    $display("[TB] 10M frame with one corrupted phase");
    drive(36, 8'h00, 1'b0);
    apply_stimulus(8'h5A, 100, -1, -1, -1, 1'b1, 1'b0, 16'd0);
    apply_stimulus(8'h5A, 100, 37, -1, -1, 1'b1, 1'b1, 16'd1);
    apply_stimulus(8'hD5, 100, -1, -1, -1, 1'b1, 1'b0, 16'd1);
    drive(20, 8'h00, 1'b0);

    $display("[TB] error counter saturation and clear priority");
    speed = 2'b01;
    drive(5, 8'h00, 1'b0);
    err_cnt_clr = 1'b1;
    drive(1, 8'h00, 1'b0);
    err_cnt_clr = 1'b0;
    check_output("sat_cnt_after_clr", 32'(err_cnt_s), 32'd0);
    drive(10, 8'h00, 1'b0);
    for (int k = 1; k <= 18; k++) begin
      apply_stimulus(8'(16 + k), 10, 3, -1, -1, 1'b1, 1'b1, 16'(k));
    end
    check_output("sat_cnt_hold", 32'(err_cnt_s), 32'hF);
    apply_stimulus(8'h40, 10, 3, -1, 9, 1'b1, 1'b1, 16'd0);
    check_output("sat_cnt_clr_wins", 32'(err_cnt_s), 32'd0);
    apply_stimulus(8'h41, 10, 3, -1, -1, 1'b1, 1'b1, 16'd1);
    drive(10, 8'h00, 1'b0);

    for (int i = 0; i < 400 && sb.size() > 0; i++) begin
      @(posedge clk);
    end
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL sb_drain: %0d entries left, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
